driver_scan_controller: RTL

Sequencer front-end for the `driver_sequencer` dot-driver memory. It walks `row_select`/`col_select` across a programmable rectangle of the dot matrix and holds each dot for a programmable dwell in a row phase and then a column phase. It waits out the sequencer's read pipeline before qualifying the firing strobe. It also arbitrates the sequencer's single memory write port, giving host writes access only outside the firing windows.

---
 rtl/driver_scan_pkg.sv | 15 +
 rtl/driver_scan_addr_gen.sv | 32 +++
 rtl/driver_scan_controller.sv | 193 +++++++++++++++++++
 3 files changed

// File: rtl/driver_scan_pkg.sv
// rtl/driver_scan_pkg.sv - shared state encoding and write-port widths for the dot scan controller
package driver_scan_pkg;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_SETUP,
        ST_ROW,
        ST_COL,
        ST_ADVANCE
    } scan_state_t;

    localparam int WR_ADDR_WIDTH = 10;
    localparam int WR_DATA_WIDTH = 16;

endpackage

// File: rtl/driver_scan_addr_gen.sv
// rtl/driver_scan_addr_gen.sv - row/column dot counter pair with step, clear and last-dot flag
module driver_scan_addr_gen #(
    parameter int ADDR_WIDTH = 6
) (
    input  logic                  clock,
    input  logic                  reset,
    input  logic                  step,
    input  logic                  clear,
    input  logic [ADDR_WIDTH-1:0] row_last,
    input  logic [ADDR_WIDTH-1:0] col_last,
    output logic [ADDR_WIDTH-1:0] row_select,
    output logic [ADDR_WIDTH-1:0] col_select,
    output logic                  last_dot
);

    assign last_dot = (row_select == row_last) && (col_select == col_last);

    always_ff @(posedge clock) begin
        if (reset || clear) begin
            row_select <= '0;
            col_select <= '0;
        end else if (step) begin
            if (col_select == col_last) begin
                col_select <= '0;
                row_select <= row_select + ADDR_WIDTH'(1);
            end else begin
                col_select <= col_select + ADDR_WIDTH'(1);
            end
        end
    end

endmodule

// File: rtl/driver_scan_controller.sv
// rtl/driver_scan_controller.sv - dot-matrix scan sequencer with write-port arbitration
// Optional DRIVER_SCAN_SKIP_EN: skip dots whose driver_enable_in is low at the end of SETUP.
module driver_scan_controller
    import driver_scan_pkg::*;
#(
    parameter int MEM_LENGTH         = 48,
    parameter int MEM_ADDRESS_LENGTH = 6,
    parameter int DWELL_WIDTH        = 16,
    parameter int PIPE_LATENCY       = 2
) (
    input  logic                          clock,
    input  logic                          reset,
    input  logic                          start,
    input  logic                          stop,
    input  logic                          continuous,
    input  logic [MEM_ADDRESS_LENGTH-1:0] row_count,
    input  logic [MEM_ADDRESS_LENGTH-1:0] col_count,
    input  logic [DWELL_WIDTH-1:0]        dwell_cycles,
    input  logic                          host_wr_valid,
    output logic                          host_wr_ready,
    input  logic [WR_ADDR_WIDTH-1:0]      host_wr_addr,
    input  logic [WR_DATA_WIDTH-1:0]      host_wr_data,
    output logic [WR_ADDR_WIDTH-1:0]      mem_address,
    output logic                          mem_write_n,
    output logic [WR_DATA_WIDTH-1:0]      data_in,
    output logic [MEM_ADDRESS_LENGTH-1:0] row_select,
    output logic [MEM_ADDRESS_LENGTH-1:0] col_select,
    output logic                          row_col_select,
    input  logic                          driver_enable_in,
    input  logic                          driver_data_in,
    output logic                          fire,
    output logic                          fire_data,
    output logic                          busy,
    output logic                          frame_done,
    output logic [7:0]                    frame_count
);

    localparam logic [DWELL_WIDTH-1:0] PIPE_LAST = DWELL_WIDTH'(PIPE_LATENCY - 1);

    scan_state_t                   state;
    logic [DWELL_WIDTH-1:0]        cnt;
    logic [DWELL_WIDTH-1:0]        cfg_dwell;
    logic [MEM_ADDRESS_LENGTH-1:0] row_last;
    logic [MEM_ADDRESS_LENGTH-1:0] col_last;
    logic                          stop_pend;
    logic                          last_dot;
    logic                          start_ok;
    logic                          stop_req;
    logic                          load_cfg;
    logic                          addr_step;
    logic                          addr_clear;
    logic                          xfer;

    // Counts above the matrix edge are clamped so the walk never leaves the array.
    function automatic logic [MEM_ADDRESS_LENGTH-1:0] last_index(
        input logic [MEM_ADDRESS_LENGTH-1:0] count
    );
        if (count > MEM_ADDRESS_LENGTH'(MEM_LENGTH))
            return MEM_ADDRESS_LENGTH'(MEM_LENGTH - 1);
        return count - MEM_ADDRESS_LENGTH'(1);
    endfunction

    assign start_ok   = start && (row_count != '0) && (col_count != '0);
    assign stop_req   = stop_pend || stop;
    assign load_cfg   = ((state == ST_IDLE) && start_ok) ||
                        ((state == ST_ADVANCE) && last_dot && !stop_req && continuous);
    assign addr_step  = (state == ST_ADVANCE) && !stop_req && !last_dot;
    assign addr_clear = ((state == ST_IDLE) && start_ok) ||
                        ((state == ST_ADVANCE) && last_dot && !stop_req);

    assign host_wr_ready = (state == ST_IDLE) || (state == ST_SETUP) || (state == ST_ADVANCE);
    assign xfer          = host_wr_valid && host_wr_ready;
    assign fire          = driver_enable_in &&
                           ((state == ST_ROW) || ((state == ST_COL) && (cnt != '0)));
    assign fire_data     = fire && driver_data_in;

    driver_scan_addr_gen #(
        .ADDR_WIDTH(MEM_ADDRESS_LENGTH)
    ) u_addr_gen (
        .clock     (clock),
        .reset     (reset),
        .step      (addr_step),
        .clear     (addr_clear),
        .row_last  (row_last),
        .col_last  (col_last),
        .row_select(row_select),
        .col_select(col_select),
        .last_dot  (last_dot)
    );

    always_ff @(posedge clock) begin
        if (reset) begin
            cfg_dwell <= '0;
            row_last  <= '0;
            col_last  <= '0;
        end else if (load_cfg) begin
            cfg_dwell <= (dwell_cycles == '0) ? DWELL_WIDTH'(1) : dwell_cycles;
            row_last  <= last_index(row_count);
            col_last  <= last_index(col_count);
        end
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            state          <= ST_IDLE;
            cnt            <= '0;
            stop_pend      <= 1'b0;
            busy           <= 1'b0;
            row_col_select <= 1'b0;
            frame_done     <= 1'b0;
            frame_count    <= 8'd0;
            mem_write_n    <= 1'b1;
            mem_address    <= '0;
            data_in        <= '0;
        end else begin
            frame_done  <= 1'b0;
            mem_write_n <= !xfer;
            mem_address <= xfer ? host_wr_addr : '0;
            data_in     <= xfer ? host_wr_data : '0;
            if (state != ST_IDLE && stop)
                stop_pend <= 1'b1;

            case (state)
                ST_IDLE: begin
                    if (start_ok) begin
                        state     <= ST_SETUP;
                        cnt       <= '0;
                        busy      <= 1'b1;
                        stop_pend <= stop;
                    end
                end
                ST_SETUP: begin
                    if (cnt == PIPE_LAST) begin
                        cnt <= '0;
`ifdef DRIVER_SCAN_SKIP_EN
                        if (!driver_enable_in) begin
                            state <= ST_ADVANCE;
                            if (last_dot) begin
                                frame_done  <= 1'b1;
                                frame_count <= frame_count + 8'd1;
                            end
                        end else begin
                            state <= ST_ROW;
                        end
`else
                        state <= ST_ROW;
`endif
                    end else begin
                        cnt <= cnt + DWELL_WIDTH'(1);
                    end
                end
                ST_ROW: begin
                    if (cnt == cfg_dwell - DWELL_WIDTH'(1)) begin
                        cnt            <= '0;
                        state          <= ST_COL;
                        row_col_select <= 1'b1;
                    end else begin
                        cnt <= cnt + DWELL_WIDTH'(1);
                    end
                end
                ST_COL: begin
                    // cnt==0 is the settle cycle, so the phase runs dwell+1 cycles.
                    if (cnt == cfg_dwell) begin
                        cnt            <= '0;
                        state          <= ST_ADVANCE;
                        row_col_select <= 1'b0;
                        if (last_dot) begin
                            frame_done  <= 1'b1;
                            frame_count <= frame_count + 8'd1;
                        end
                    end else begin
                        cnt <= cnt + DWELL_WIDTH'(1);
                    end
                end
                ST_ADVANCE: begin
                    cnt <= '0;
                    if (stop_req || (last_dot && !continuous)) begin
                        state     <= ST_IDLE;
                        busy      <= 1'b0;
                        stop_pend <= 1'b0;
                    end else begin
                        state <= ST_SETUP;
                    end
                end
                default: begin
                    state <= ST_IDLE;
                    busy  <= 1'b0;
                end
            endcase
        end
    end

endmodule
